fractal_sync_rx_mc: RTL

Multi-channel successor of the single-port fractal synchronization rx datapath. It has N_CH independent request inputs, one per child node/port of a tree level. Each channel samples its request, decodes barrier/lock/free, and reports local/root status to the register file. Requests that must propagate go into a per-channel FIFO. A round-robin arbiter merges the FIFOs into one valid/ready output stream towards the next tree level, with sticky overflow error reporting.

---
 rtl/fractal_sync_rx_mc.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fractal_sync_rx_mc.sv
// fractal_sync_rx_mc: multi-channel fractal synchronization rx datapath.
// Each channel samples barrier/lock/free requests, reports status to the
// register file, queues requests to propagate in its own FIFO, and a
// round-robin arbiter merges all FIFOs into one valid/ready stream.
//
// Stream handshake: an element transfers on a clk_i edge where out_valid_o
// and out_ready_i are both high; once out_valid_o is raised, the grant and
// the payload stay stable until that transfer happens.
//
// Optional build macro FRACTAL_SYNC_RX_MC_STATS_EN: when defined, adds
// per-channel 8-bit saturating drop counters on drop_cnt_o; when undefined,
// drop_cnt_o is tied to zero.
module fractal_sync_rx_mc #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned AGGR_W     = 8,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter bit          COMB_IN    = 1'b0,
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_CH-1:0]          req_sync_i,
  input  logic [N_CH-1:0]          req_lock_i,
  input  logic [N_CH-1:0]          req_free_i,
  input  logic [N_CH*AGGR_W-1:0]   req_aggr_i,
  input  logic [N_CH*ID_W-1:0]     req_id_i,
  output logic [N_CH-1:0]          check_propagate_o,
  output logic [N_CH-1:0]          local_o,
  output logic [N_CH-1:0]          root_o,
  output logic [N_CH-1:0]          lock_o,
  output logic [N_CH-1:0]          free_o,
  input  logic [N_CH-1:0]          propagate_lock_i,
  output logic [N_CH-1:0]          error_overflow_o,
  input  logic                     clear_err_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_sync_o,
  output logic                     out_lock_o,
  output logic                     out_free_o,
  output logic [AGGR_W-1:0]        out_aggr_o,
  output logic [ID_W-1:0]          out_id_o,
  output logic [CH_W-1:0]          out_ch_o,
  output logic [N_CH*8-1:0]        drop_cnt_o
);

  // Element layout: {sync, lock, free, aggr, id}
  localparam int unsigned E_W   = 3 + AGGR_W + ID_W;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [N_CH-1:0]           nonempty;
  logic [N_CH-1:0][E_W-1:0]  head_w;
  logic [CH_W-1:0]           grant;
  logic                      handshake;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic              s_sync, s_lock, s_free;
    logic [AGGR_W-1:0] s_aggr;
    logic [ID_W-1:0]   s_id;
    logic              push, pop, full, wr_en, overflow;
    logic [E_W-1:0]    elem;
    logic [E_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    if (COMB_IN) begin : g_comb
      assign s_sync = req_sync_i[c];
      assign s_lock = req_lock_i[c];
      assign s_free = req_free_i[c];
      assign s_aggr = req_aggr_i[c*AGGR_W +: AGGR_W];
      assign s_id   = req_id_i[c*ID_W +: ID_W];
    end else begin : g_reg
      logic              sync_q, lock_q, free_q;
      logic [AGGR_W-1:0] aggr_q;
      logic [ID_W-1:0]   id_q;
      // Flags follow the inputs every cycle; payload only moves on a request.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          sync_q <= 1'b0;
          lock_q <= 1'b0;
          free_q <= 1'b0;
          aggr_q <= '0;
          id_q   <= '0;
        end else begin
          sync_q <= req_sync_i[c];
          lock_q <= req_lock_i[c];
          free_q <= req_free_i[c];
          if (req_sync_i[c] | req_lock_i[c] | req_free_i[c]) begin
            aggr_q <= req_aggr_i[c*AGGR_W +: AGGR_W];
            id_q   <= req_id_i[c*ID_W +: ID_W];
          end
        end
      end
      assign s_sync = sync_q;
      assign s_lock = lock_q;
      assign s_free = free_q;
      assign s_aggr = aggr_q;
      assign s_id   = id_q;
    end

    assign check_propagate_o[c] = s_sync;
    assign local_o[c]           = s_sync & s_aggr[0];
    assign root_o[c]            = (s_aggr == AGGR_W'(1));
    assign lock_o[c]            = s_lock;
    assign free_o[c]            = s_free;

    // A barrier leaves this level when aggr[0] is clear; the shifted mask is
    // what the parent level decodes.
    assign push     = (s_sync & ~s_aggr[0]) | propagate_lock_i[c];
    assign elem     = {s_sync, s_lock, s_free,
                       (s_sync ? (s_aggr >> 1) : s_aggr), s_id};
    assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop      = handshake & (grant == CH_W'(c));
    assign wr_en    = push & (~full | pop);
    assign overflow = push & full & ~pop;
    assign nonempty[c] = (cnt_q != '0);
    assign head_w[c]   = mem_q[rd_q];

    // Circular FIFO; a full FIFO may accept a push in the cycle it pops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (wr_en) begin
          mem_q[wr_q] <= elem;
          wr_q <= (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_q <= (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        end
        cnt_q <= cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
      end
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= (err_q & ~clear_err_i) | overflow;
    end
    assign error_overflow_o[c] = err_q;

`ifdef FRACTAL_SYNC_RX_MC_STATS_EN
    logic [7:0] drop_q;
    // Saturating drop counter; clear restarts the count from this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          drop_q <= '0;
      else if (clear_err_i) drop_q <= {7'd0, overflow};
      else if (overflow && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
    end
    assign drop_cnt_o[c*8 +: 8] = drop_q;
`else
    assign drop_cnt_o[c*8 +: 8] = 8'd0;
`endif
  end

  logic [CH_W-1:0] ptr_q, grant_q, rr_grant;
  logic            hold_q;
  int unsigned     idx;

  // First non-empty channel at or after the round-robin pointer.
  always_comb begin
    rr_grant = '0;
    idx      = 0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N_CH;
      if (nonempty[idx]) rr_grant = CH_W'(idx);
    end
  end

  assign out_valid_o = |nonempty;
  assign grant       = hold_q ? grant_q : rr_grant;
  assign handshake   = out_valid_o & out_ready_i;

  // Freeze the grant while a stalled element is offered; advance on transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      grant_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      hold_q  <= out_valid_o & ~out_ready_i;
      grant_q <= grant;
      if (handshake) begin
        ptr_q <= ((int'(grant) + 1) >= N_CH) ? '0 : grant + CH_W'(1);
      end
    end
  end

  always_comb begin
    {out_sync_o, out_lock_o, out_free_o, out_aggr_o, out_id_o} = '0;
    out_ch_o = '0;
    if (out_valid_o) begin
      {out_sync_o, out_lock_o, out_free_o, out_aggr_o, out_id_o} = head_w[grant];
      out_ch_o = grant;
    end
  end

endmodule
